// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth product accumulator.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PROD_W      = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_MAX_CNT = 16;

endpackage

// File: rtl/booth_sat_add.sv
// Signed saturating adder: clamps to the ACC_W two's-complement range and
// flags whenever a clamp happened.
module booth_sat_add #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full;

    // One guard bit exposes overflow as a mismatch of the two top bits.
    always_comb begin
        full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ovf  = full[ACC_W] != full[ACC_W-1];
        if (!ovf)
            sum = full[ACC_W-1:0];
        else if (full[ACC_W])
            sum = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sum = {1'b0, {(ACC_W-1){1'b1}}};
    end

endmodule

// File: rtl/booth_acc.sv
// Frame accumulator for signed Booth products.
//
// state | meaning
// IDLE  | waiting for the first product of a frame
// ACC   | frame open, adding products
// HOLD  | frame closed, result presented until taken
module booth_acc
    import booth_pkg::*;
#(
    parameter  int ACC_W   = DEF_ACC_W,
    parameter  int MAX_CNT = DEF_MAX_CNT,
    localparam int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              p_valid,
    input  logic [PROD_W-1:0] p,
    input  logic              p_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_sat
);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             sat, sat_nxt;
    logic             rdy;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;

    assign p_ext   = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    assign accept  = p_valid && rdy;
    assign cnt_inc = cnt + CNT_W'(1);

    booth_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (p_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state and datapath update; the closing product moves us to HOLD.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = p_ext;
                    cnt_nxt   = CNT_W'(1);
                    sat_nxt   = 1'b0;
                    state_nxt = (p_last || MAX_CNT == 1) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_nxt   = add_sum;
                    cnt_nxt   = cnt_inc;
                    sat_nxt   = sat | add_ovf;
                    state_nxt = (p_last || cnt_inc == CNT_W'(MAX_CNT)) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                sat_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; in_ready is registered so it stays low
    // through reset and rises on the first edge after release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
            rdy   <= (state_nxt != HOLD);
        end
    end

    assign in_ready  = rdy;
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_cnt   = cnt;
    assign out_sat   = sat;

endmodule

// File: tb/tb_booth_acc.sv
// Directed bench for booth_acc: a default instance (ACC_W=24) and a narrow
// instance (ACC_W=18) driven by the same stimulus, so saturation can be seen.
module tb_booth_acc;

    logic        clock;
    logic        rst_n;
    logic        p_valid;
    logic [15:0] p;
    logic        p_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_sat;
    logic [23:0] out_sum;
    logic [4:0]  out_cnt;

    logic        in_ready_n, out_valid_n, out_sat_n;
    logic [17:0] out_sum_n;
    logic [4:0]  out_cnt_n;

    int nvec = 0;
    int nerr = 0;

    booth_acc dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .p_valid   (p_valid),
        .p         (p),
        .p_last    (p_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_sat   (out_sat)
    );

    booth_acc #(.ACC_W(18)) dut_n (
        .clock     (clock),
        .rst_n     (rst_n),
        .p_valid   (p_valid),
        .p         (p),
        .p_last    (p_last),
        .in_ready  (in_ready_n),
        .out_valid (out_valid_n),
        .out_ready (out_ready),
        .out_sum   (out_sum_n),
        .out_cnt   (out_cnt_n),
        .out_sat   (out_sat_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one product for exactly one accepting edge.
    task automatic push(input logic [15:0] v, input logic last);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
        p_valid = 1'b1;
        p       = v;
        p_last  = last;
        step();
        p_valid = 1'b0;
        p_last  = 1'b0;
        p       = 16'hDEAD;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        p_valid   = 1'b0;
        p         = 16'h0;
        p_last    = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sum",   {8'd0, out_sum}, 32'd0);
        chk("rst_cnt",   {27'd0, out_cnt}, 32'd0);
        chk("rst_sat",   {31'd0, out_sat}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Basic frame with the consumer always ready.
        out_ready = 1'b1;
        push(16'd12, 1'b0);
        push(16'd20, 1'b0);
        push(16'd30, 1'b1);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_sum",   {8'd0, out_sum}, 32'd62);
        chk("basic_cnt",   {27'd0, out_cnt}, 32'd3);
        chk("basic_sat",   {31'd0, out_sat}, 32'd0);
        chk("basic_hold_rdy", {31'd0, in_ready}, 32'd0);
        step();
        chk("basic_valid_1cyc", {31'd0, out_valid}, 32'd0);
        chk("basic_idle_rdy",   {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Most negative single product, then backpressure and a HOLD attempt.
        push(16'h8000, 1'b1);
        chk("neg_sum", {8'd0, out_sum}, 32'h00FF8000);
        chk("neg_cnt", {27'd0, out_cnt}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            p_valid = (i == 2);
            p       = 16'd1000;
            p_last  = 1'b1;
            step();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum",   {8'd0, out_sum}, 32'h00FF8000);
            chk("bp_cnt",   {27'd0, out_cnt}, 32'd1);
        end
        p_valid = 1'b0;
        p_last  = 1'b0;
        release_frame();
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_rel_sum",   {8'd0, out_sum}, 32'd0);
        chk("bp_rel_cnt",   {27'd0, out_cnt}, 32'd0);

        // Mixed signs: -100 + 40 = -60.
        push(16'hFF9C, 1'b0);
        push(16'd40, 1'b1);
        chk("mix_sum", {8'd0, out_sum}, 32'h00FFFFC4);
        chk("mix_cnt", {27'd0, out_cnt}, 32'd2);
        release_frame();

        // Positive saturation on the narrow instance only.
        for (int i = 0; i < 5; i++) push(16'd32767, i == 4);
        chk("psat_sum_n", {14'd0, out_sum_n}, 32'd131071);
        chk("psat_sat_n", {31'd0, out_sat_n}, 32'd1);
        chk("psat_cnt_n", {27'd0, out_cnt_n}, 32'd5);
        chk("psat_sum",   {8'd0, out_sum}, 32'd163835);
        chk("psat_sat",   {31'd0, out_sat}, 32'd0);
        release_frame();
        chk("psat_clr_n", {31'd0, out_sat_n}, 32'd0);

        // Negative saturation: four products land exactly on the minimum,
        // the fifth would pass it.
        for (int i = 0; i < 5; i++) push(16'h8000, i == 4);
        chk("nsat_sum_n", {14'd0, out_sum_n}, 32'h00020000);
        chk("nsat_sat_n", {31'd0, out_sat_n}, 32'd1);
        chk("nsat_sum",   {8'd0, out_sum}, 32'h00FD8000);
        release_frame();

        // Auto-close after MAX_CNT products; a 17th is refused in HOLD.
        for (int i = 0; i < 16; i++) begin
            push(16'd1, 1'b0);
            if (i == 14) chk("auto_open", {31'd0, out_valid}, 32'd0);
        end
        chk("auto_valid", {31'd0, out_valid}, 32'd1);
        chk("auto_sum",   {8'd0, out_sum}, 32'd16);
        chk("auto_cnt",   {27'd0, out_cnt}, 32'd16);
        p_valid = 1'b1;
        p       = 16'd1;
        step();
        p_valid = 1'b0;
        chk("auto_17_sum",   {8'd0, out_sum}, 32'd16);
        chk("auto_17_cnt",   {27'd0, out_cnt}, 32'd16);
        chk("auto_17_valid", {31'd0, out_valid}, 32'd1);
        release_frame();

        // Reset mid-frame discards the partial sum.
        push(16'd7, 1'b0);
        push(16'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_sum",   {8'd0, out_sum}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        push(16'd5, 1'b1);
        chk("mid_new_sum", {8'd0, out_sum}, 32'd5);
        chk("mid_new_cnt", {27'd0, out_cnt}, 32'd1);
        release_frame();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
